// File: rtl/uart_tx_buffered.sv
// -----------------------------------------------------------------------------
// uart_tx_buffered
//   Buffered 8N1 UART transmitter. CPU writes are queued in a small FIFO and
//   serialised LSB first on uart_tx. An optional even-parity bit can be placed
//   between D7 and the stop bit. When the stop bit ends and another byte is
//   waiting, the next start bit follows immediately, with no idle cycle.
//
// Parameters
//   BAUD_DIV    sysclk cycles per bit (2..65535)
//   FIFO_DEPTH  FIFO entries, power of two (2..16)
//   PARITY_EN   1 = insert even-parity bit after D7
//
// Ports
//   sysclk    in   clock, all logic on the rising edge
//   reset     in   synchronous, active-high; aborts any frame, empties the FIFO
//   tx_data   in   [7:0] byte to enqueue
//   tx_wr     in   write strobe, one byte per cycle while high
//   tx_full   out  FIFO holds FIFO_DEPTH entries (registered)
//   tx_empty  out  FIFO holds no entries (registered)
//   tx_level  out  [4:0] FIFO occupancy (registered)
//   tx_busy   out  transmitter is not idle (registered)
//   tx_ovf    out  one-cycle pulse after a write was dropped because the FIFO was full
//   uart_tx   out  serial line, idle high (registered)
// -----------------------------------------------------------------------------
module uart_tx_buffered #(
    parameter int BAUD_DIV   = 5208,
    parameter int FIFO_DEPTH = 8,
    parameter int PARITY_EN  = 0
) (
    input  logic       sysclk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_wr,
    output logic       tx_full,
    output logic       tx_empty,
    output logic [4:0] tx_level,
    output logic       tx_busy,
    output logic       tx_ovf,
    output logic       uart_tx
);

    localparam int               PTR_W     = $clog2(FIFO_DEPTH);
    localparam logic [15:0]      BAUD_LAST = 16'(BAUD_DIV - 1);
    localparam logic [4:0]       DEPTH_L   = 5'(FIFO_DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
    localparam logic             PAR_ON    = (PARITY_EN != 0);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    // Even parity: the bit that makes the total count of ones even.
    function automatic logic even_parity(input logic [7:0] d);
        return ^d;
    endfunction

    // FIFO storage and pointers
    logic [7:0]       mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;

    // Transmitter state
    state_t      state_r;
    state_t      state_nx;
    logic [15:0] baud_cnt_r;
    logic [15:0] baud_cnt_nx;
    logic [2:0]  bit_idx_r;
    logic [2:0]  bit_idx_nx;
    logic [7:0]  shift_r;
    logic [7:0]  shift_nx;
    logic        parity_r;
    logic        parity_nx;
    logic        line_nx;
    logic        busy_nx;

    // Handshake / flag helpers
    logic        push_s;
    logic        pop_s;
    logic        ovf_s;
    logic        bit_end_s;
    logic [7:0]  head_s;
    logic [4:0]  level_nx;

    // Flags used here are the registered ones, so a write that arrives while
    // the FIFO is full is rejected even if a pop happens on the same edge.
    assign push_s    = tx_wr && !tx_full;
    assign ovf_s     = tx_wr && tx_full;
    assign bit_end_s = (baud_cnt_r == BAUD_LAST);
    assign head_s    = mem_r[rd_ptr_r];

    // Next-state and datapath decode for the serialiser
    always_comb begin
        state_nx    = state_r;
        baud_cnt_nx = baud_cnt_r;
        bit_idx_nx  = bit_idx_r;
        shift_nx    = shift_r;
        parity_nx   = parity_r;
        line_nx     = uart_tx;
        pop_s       = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (!tx_empty) begin
                    pop_s       = 1'b1;
                    shift_nx    = head_s;
                    parity_nx   = even_parity(head_s);
                    line_nx     = 1'b0;
                    baud_cnt_nx = 16'd0;
                    state_nx    = ST_START;
                end else begin
                    line_nx     = 1'b1;
                    baud_cnt_nx = 16'd0;
                end
            end

            ST_START: begin
                if (bit_end_s) begin
                    line_nx     = shift_r[0];
                    bit_idx_nx  = 3'd0;
                    baud_cnt_nx = 16'd0;
                    state_nx    = ST_DATA;
                end else begin
                    baud_cnt_nx = baud_cnt_r + 16'd1;
                end
            end

            ST_DATA: begin
                if (bit_end_s) begin
                    baud_cnt_nx = 16'd0;
                    if (bit_idx_r == 3'd7) begin
                        if (PAR_ON) begin
                            line_nx  = parity_r;
                            state_nx = ST_PARITY;
                        end else begin
                            line_nx  = 1'b1;
                            state_nx = ST_STOP;
                        end
                    end else begin
                        bit_idx_nx = bit_idx_r + 3'd1;
                        line_nx    = shift_r[bit_idx_r + 3'd1];
                    end
                end else begin
                    baud_cnt_nx = baud_cnt_r + 16'd1;
                end
            end

            ST_PARITY: begin
                if (bit_end_s) begin
                    line_nx     = 1'b1;
                    baud_cnt_nx = 16'd0;
                    state_nx    = ST_STOP;
                end else begin
                    baud_cnt_nx = baud_cnt_r + 16'd1;
                end
            end

            ST_STOP: begin
                if (bit_end_s) begin
                    baud_cnt_nx = 16'd0;
                    // Chain straight into the next start bit when data is waiting.
                    if (!tx_empty) begin
                        pop_s     = 1'b1;
                        shift_nx  = head_s;
                        parity_nx = even_parity(head_s);
                        line_nx   = 1'b0;
                        state_nx  = ST_START;
                    end else begin
                        line_nx   = 1'b1;
                        state_nx  = ST_IDLE;
                    end
                end else begin
                    baud_cnt_nx = baud_cnt_r + 16'd1;
                end
            end

            default: begin
                state_nx    = ST_IDLE;
                line_nx     = 1'b1;
                baud_cnt_nx = 16'd0;
                bit_idx_nx  = 3'd0;
            end
        endcase

        busy_nx = (state_nx != ST_IDLE);
    end

    // FIFO occupancy after this edge's push/pop
    always_comb begin
        case ({push_s, pop_s})
            2'b10:   level_nx = tx_level + 5'd1;
            2'b01:   level_nx = tx_level - 5'd1;
            default: level_nx = tx_level;
        endcase
    end

    // FIFO data array write port (contents need no reset; pointers define validity)
    always_ff @(posedge sysclk) begin
        if (!reset && push_s) begin
            mem_r[wr_ptr_r] <= tx_data;
        end
    end

    // FIFO pointers, flags and overflow pulse
    always_ff @(posedge sysclk) begin
        if (reset) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            tx_level <= 5'd0;
            tx_empty <= 1'b1;
            tx_full  <= 1'b0;
            tx_ovf   <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            tx_level <= level_nx;
            tx_empty <= (level_nx == 5'd0);
            tx_full  <= (level_nx == DEPTH_L);
            tx_ovf   <= ovf_s;
        end
    end

    // Serialiser state register and registered line/busy outputs
    always_ff @(posedge sysclk) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            baud_cnt_r <= 16'd0;
            bit_idx_r  <= 3'd0;
            shift_r    <= 8'd0;
            parity_r   <= 1'b0;
            uart_tx    <= 1'b1;
            tx_busy    <= 1'b0;
        end else begin
            state_r    <= state_nx;
            baud_cnt_r <= baud_cnt_nx;
            bit_idx_r  <= bit_idx_nx;
            shift_r    <= shift_nx;
            parity_r   <= parity_nx;
            uart_tx    <= line_nx;
            tx_busy    <= busy_nx;
        end
    end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_buffered
//   Two instances share one stimulus stream: dut0 without parity, dut1 with
//   even parity, both BAUD_DIV=4, FIFO_DEPTH=8. A queue-based model per
//   instance predicts every output every cycle; a table of hand-computed
//   expectations at fixed cycles pins the model itself.
// -----------------------------------------------------------------------------
module tb_uart_tx_buffered;

    localparam int BAUD  = 4;
    localparam int DEPTH = 8;

    logic       sysclk = 1'b0;
    logic       reset  = 1'b1;
    logic [7:0] tx_data = 8'd0;
    logic       tx_wr   = 1'b0;

    logic       o0_full, o0_empty, o0_busy, o0_ovf, o0_tx;
    logic [4:0] o0_level;
    logic       o1_full, o1_empty, o1_busy, o1_ovf, o1_tx;
    logic [4:0] o1_level;

    int cyc = 0;
    int n_checks = 0;
    int n_pass = 0;

    // Hand-computed expectations: at cycle pin_cyc, signal pin_kind equals pin_val
    int         pin_cyc  [128];
    int         pin_kind [128];
    logic [4:0] pin_val  [128];
    int         n_pins = 0;

    uart_tx_buffered #(.BAUD_DIV(BAUD), .FIFO_DEPTH(DEPTH), .PARITY_EN(0)) dut0 (
        .sysclk(sysclk), .reset(reset), .tx_data(tx_data), .tx_wr(tx_wr),
        .tx_full(o0_full), .tx_empty(o0_empty), .tx_level(o0_level),
        .tx_busy(o0_busy), .tx_ovf(o0_ovf), .uart_tx(o0_tx)
    );

    uart_tx_buffered #(.BAUD_DIV(BAUD), .FIFO_DEPTH(DEPTH), .PARITY_EN(1)) dut1 (
        .sysclk(sysclk), .reset(reset), .tx_data(tx_data), .tx_wr(tx_wr),
        .tx_full(o1_full), .tx_empty(o1_empty), .tx_level(o1_level),
        .tx_busy(o1_busy), .tx_ovf(o1_ovf), .uart_tx(o1_tx)
    );

    always #5 sysclk = ~sysclk;

    // Edge counter: at the negedge after rising edge k, cyc == k
    always @(posedge sysclk) cyc <= cyc + 1;

    // Behavioural model: a byte queue plus a per-cycle waveform of the frame on the wire
    for (genvar g = 0; g < 2; g++) begin : mdl
        localparam bit PE = (g == 1);
        logic [7:0] fq [$];
        logic       wq [$];
        logic       e_tx, e_busy, e_ovf, e_full, e_empty;
        logic [4:0] e_level;

        always @(posedge sysclk) begin
            logic [7:0] b;
            logic       t_tx, t_busy, t_ovf;
            bit         full_pre, empty_pre;
            if (reset) begin
                fq.delete();
                wq.delete();
                t_tx   = 1'b1;
                t_busy = 1'b0;
                t_ovf  = 1'b0;
            end else begin
                full_pre  = (fq.size() == DEPTH);
                empty_pre = (fq.size() == 0);
                t_ovf     = tx_wr && full_pre;
                if (wq.size() == 0 && !empty_pre) begin
                    b = fq.pop_front();
                    for (int k = 0; k < BAUD; k++) wq.push_back(1'b0);
                    for (int i = 0; i < 8; i++)
                        for (int k = 0; k < BAUD; k++) wq.push_back(b[i]);
                    if (PE)
                        for (int k = 0; k < BAUD; k++) wq.push_back(^b);
                    for (int k = 0; k < BAUD; k++) wq.push_back(1'b1);
                end
                if (tx_wr && !full_pre) fq.push_back(tx_data);
                if (wq.size() > 0) begin
                    t_tx   = wq.pop_front();
                    t_busy = 1'b1;
                end else begin
                    t_tx   = 1'b1;
                    t_busy = 1'b0;
                end
            end
            e_tx    <= t_tx;
            e_busy  <= t_busy;
            e_ovf   <= t_ovf;
            e_level <= 5'(fq.size());
            e_full  <= (fq.size() == DEPTH);
            e_empty <= (fq.size() == 0);
        end
    end

    function automatic logic [4:0] pin_actual(input int kind);
        case (kind)
            0: return {4'd0, o0_tx};
            1: return {4'd0, o0_busy};
            2: return o0_level;
            3: return {4'd0, o0_ovf};
            4: return {4'd0, o0_full};
            5: return {4'd0, o1_tx};
            6: return {4'd0, o1_busy};
            default: return 5'd31;
        endcase
    endfunction

    // Single compare process: model vs both DUTs every cycle, plus pinned literals
    always @(negedge sysclk) begin
        logic [9:0] a0, e0, a1, e1;
        logic [4:0] pa;
        if (cyc >= 1) begin
            a0 = {o0_tx, o0_busy, o0_ovf, o0_full, o0_empty, o0_level};
            e0 = {mdl[0].e_tx, mdl[0].e_busy, mdl[0].e_ovf, mdl[0].e_full, mdl[0].e_empty, mdl[0].e_level};
            a1 = {o1_tx, o1_busy, o1_ovf, o1_full, o1_empty, o1_level};
            e1 = {mdl[1].e_tx, mdl[1].e_busy, mdl[1].e_ovf, mdl[1].e_full, mdl[1].e_empty, mdl[1].e_level};
            n_checks++;
            if (a0 === e0) n_pass++;
            else $display("FAIL model_dut0 cyc=%0d got tx,busy,ovf,full,empty,level=%b want %b", cyc, a0, e0);
            n_checks++;
            if (a1 === e1) n_pass++;
            else $display("FAIL model_dut1 cyc=%0d got tx,busy,ovf,full,empty,level=%b want %b", cyc, a1, e1);
            for (int i = 0; i < n_pins; i++) begin
                if (pin_cyc[i] == cyc) begin
                    pa = pin_actual(pin_kind[i]);
                    n_checks++;
                    if (pa === pin_val[i]) n_pass++;
                    else $display("FAIL pin%0d kind=%0d cyc=%0d got %0d want %0d", i, pin_kind[i], cyc, pa, pin_val[i]);
                end
            end
        end
    end

    task automatic add_pin(input int c, input int kind, input logic [4:0] v);
        pin_cyc[n_pins]  = c;
        pin_kind[n_pins] = kind;
        pin_val[n_pins]  = v;
        n_pins++;
    endtask

    task automatic wait_to(input int c);
        while (cyc < c) @(negedge sysclk);
    endtask

    // Single write; returns the rising edge on which it is sampled
    task automatic write_byte(input logic [7:0] d, output int edge_n);
        edge_n  = cyc + 1;
        tx_data = d;
        tx_wr   = 1'b1;
        @(negedge sysclk);
        tx_wr   = 1'b0;
    endtask

    initial begin
        int n;
        logic [7:0] a5;
        a5 = 8'hA5;

        // 1: reset for 3 cycles, then idle
        add_pin(3, 0, 5'd1);
        add_pin(3, 2, 5'd0);
        add_pin(3, 1, 5'd0);
        repeat (3) @(negedge sysclk);
        reset = 1'b0;
        wait_to(cyc + 100);

        // 2: single byte 0xA5
        n = cyc + 1;
        add_pin(n, 2, 5'd1);
        add_pin(n + 1, 0, 5'd0);
        add_pin(n + 1, 2, 5'd0);
        for (int i = 0; i < 8; i++) add_pin(n + 6 + 4 * i, 0, {4'd0, a5[i]});
        add_pin(n + 38, 0, 5'd1);
        add_pin(n + 40, 1, 5'd1);
        add_pin(n + 41, 1, 5'd0);
        write_byte(8'hA5, n);
        wait_to(n + 60);

        // 3: burst of 10 writes, 10th dropped
        n = cyc + 1;
        add_pin(n + 8, 2, 5'd8);
        add_pin(n + 8, 4, 5'd1);
        add_pin(n + 9, 3, 5'd1);
        add_pin(n + 9, 2, 5'd8);
        add_pin(n + 10, 3, 5'd0);
        add_pin(n + 40, 0, 5'd1);
        add_pin(n + 41, 0, 5'd0);
        add_pin(n + 41, 2, 5'd7);
        add_pin(n + 360, 1, 5'd1);
        add_pin(n + 361, 1, 5'd0);
        for (int i = 0; i < 10; i++) begin
            tx_data = 8'(i);
            tx_wr   = 1'b1;
            @(negedge sysclk);
        end
        tx_wr = 1'b0;
        wait_to(n + 430);

        // 4: FIFO full, write lands on the STOP-end pop edge
        n = cyc + 1;
        for (int i = 0; i < 9; i++) begin
            tx_data = 8'h40 + 8'(i);
            tx_wr   = 1'b1;
            @(negedge sysclk);
        end
        tx_wr = 1'b0;
        add_pin(n + 40, 2, 5'd8);
        add_pin(n + 41, 3, 5'd1);
        add_pin(n + 41, 2, 5'd7);
        add_pin(n + 42, 2, 5'd8);
        add_pin(n + 42, 4, 5'd1);
        add_pin(n + 42, 3, 5'd0);
        wait_to(n + 40);
        tx_data = 8'hEE;
        tx_wr   = 1'b1;
        @(negedge sysclk);
        tx_data = 8'hEF;
        @(negedge sysclk);
        tx_wr = 1'b0;
        wait_to(n + 480);

        // 5: parity on dut1: 0x07 -> parity 1, 44-cycle frame; 0x03 -> parity 0
        n = cyc + 1;
        add_pin(n + 34, 5, 5'd0);
        add_pin(n + 38, 5, 5'd1);
        add_pin(n + 42, 5, 5'd1);
        add_pin(n + 44, 6, 5'd1);
        add_pin(n + 45, 6, 5'd0);
        write_byte(8'h07, n);
        wait_to(n + 60);
        n = cyc + 1;
        add_pin(n + 10, 5, 5'd1);
        add_pin(n + 38, 5, 5'd0);
        write_byte(8'h03, n);
        wait_to(n + 60);

        // 6: reset mid-DATA of 0x55 with 3 bytes queued
        n = cyc + 1;
        add_pin(n + 14, 2, 5'd3);
        add_pin(n + 15, 0, 5'd1);
        add_pin(n + 15, 2, 5'd0);
        add_pin(n + 15, 1, 5'd0);
        add_pin(n + 15, 5, 5'd1);
        add_pin(n + 60, 1, 5'd0);
        for (int i = 0; i < 4; i++) begin
            tx_data = (i == 0) ? 8'h55 : 8'h11 * 8'(i);
            tx_wr   = 1'b1;
            @(negedge sysclk);
        end
        tx_wr = 1'b0;
        wait_to(n + 14);
        reset = 1'b1;
        @(negedge sysclk);
        reset = 1'b0;
        wait_to(n + 115);

        // Recovery after reset
        n = cyc + 1;
        add_pin(n + 1, 0, 5'd0);
        write_byte(8'h3C, n);
        wait_to(n + 60);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
